// File: rtl/ddr_cmd_fsm.sv
// ddr_cmd_fsm: DDR command sequencer; request handshake, bank timing and auto-refresh scheduling.
// Latency: accepted request enters ACTIVE on the next cycle; every output is registered.
// Backpressure: req_ready only in IDLE with init_done and no refresh pending; user holds the request.
module ddr_cmd_fsm #(
  parameter int T_RCD        = 2,
  parameter int CAS_LAT      = 2,
  parameter int BURST_LEN    = 8,
  parameter int T_WR_RP      = 4,
  parameter int T_RP         = 2,
  parameter int T_RFC        = 10,
  parameter int REF_INTERVAL = 1560
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_done,
  input  logic        req_valid,
  input  logic        req_wr,
  input  logic [24:0] req_addr,
  output logic        req_ready,
  output logic [3:0]  cmd_state,
  output logic [24:0] ctrl_addr,
  output logic        rd_data_en,
  output logic        wr_data_en,
  output logic        done,
  output logic        ref_overrun
);

  // Shared command-state encoding decoded by the command generator.
  typedef enum logic [3:0] {
    C_IDLE      = 4'd0,
    C_ACTIVE    = 4'd1,
    C_WAIT_RCD  = 4'd2,
    C_READ      = 4'd3,
    C_WAIT_CAS  = 4'd4,
    C_WAIT_RBST = 4'd5,
    C_WRITE     = 4'd6,
    C_WAIT_WBST = 4'd7,
    C_WAIT_WREC = 4'd8,
    C_AUTOREF   = 4'd9,
    C_WAIT_RFC  = 4'd10,
    C_DONE      = 4'd11,
    C_REF_DONE  = 4'd12
  } state_t;

  // Wait counters load N-1 on entry so a state lasts exactly N cycles.
  localparam int CW = 16;
  localparam logic [CW-1:0] LD_RCD  = CW'(T_RCD - 1);
  localparam logic [CW-1:0] LD_CAS  = CW'(CAS_LAT - 1);
  localparam logic [CW-1:0] LD_BST  = CW'(BURST_LEN / 2 - 1);
  localparam logic [CW-1:0] LD_WREC = CW'(T_WR_RP - 1);
  localparam logic [CW-1:0] LD_RP   = CW'(T_RP - 1);
  localparam logic [CW-1:0] LD_RFC  = CW'(T_RFC - 1);

  localparam int TW = $clog2(REF_INTERVAL) + 1;
  localparam logic [TW-1:0] REF_LAST = TW'(REF_INTERVAL - 1);

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          is_wr, is_wr_nx;
  logic [24:0]   addr_nx;
  logic [TW-1:0] ref_tmr, ref_tmr_nx;
  logic          ref_pend, ref_pend_nx;
  logic          ovr_nx;
  logic          ref_wrap;
  logic          hs;

  // req_ready is only ever high in IDLE, so this is the IDLE handshake.
  assign hs        = req_valid && req_ready;
  assign cmd_state = state;

  // Refresh interval timer: free-runs while init_done, parked at 0 otherwise.
  always_comb begin
    ref_tmr_nx = '0;
    ref_wrap   = 1'b0;
    if (init_done) begin
      if (ref_tmr == REF_LAST) begin
        ref_wrap = 1'b1;
      end else begin
        ref_tmr_nx = ref_tmr + TW'(1);
      end
    end
  end

  // Refresh request bookkeeping: a wrap always (re)arms the request, so a wrap
  // landing on the same cycle that IDLE hands off to AUTOREFRESH keeps a second
  // refresh queued; any wrap that finds a refresh still owed flags an overrun.
  always_comb begin
    ref_pend_nx = ref_pend;
    if (ref_wrap) begin
      ref_pend_nx = 1'b1;
    end else if (state == C_IDLE && ref_pend) begin
      ref_pend_nx = 1'b0;
    end
    ovr_nx = ref_overrun | (ref_wrap & ref_pend);
  end

  // Next-state, wait-counter and request-latch logic.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    is_wr_nx = is_wr;
    addr_nx  = ctrl_addr;
    case (state)
      C_IDLE: begin
        if (ref_pend) begin
          state_nx = C_AUTOREF;
        end else if (hs) begin
          state_nx = C_ACTIVE;
          addr_nx  = req_addr;
          is_wr_nx = req_wr;
        end
      end
      C_ACTIVE: begin
        state_nx = C_WAIT_RCD;
        cnt_nx   = LD_RCD;
      end
      C_WAIT_RCD: begin
        if (cnt == '0) begin
          state_nx = is_wr ? C_WRITE : C_READ;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      // READ/WRITE carry auto-precharge; no explicit precharge is ever issued.
      C_READ: begin
        state_nx = C_WAIT_CAS;
        cnt_nx   = LD_CAS;
      end
      C_WAIT_CAS: begin
        if (cnt == '0) begin
          state_nx = C_WAIT_RBST;
          cnt_nx   = LD_BST;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      C_WAIT_RBST: begin
        if (cnt == '0) begin
          // DONE after a read also covers the auto-precharge time.
          state_nx = C_DONE;
          cnt_nx   = LD_RP;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      C_WRITE: begin
        state_nx = C_WAIT_WBST;
        cnt_nx   = LD_BST;
      end
      C_WAIT_WBST: begin
        if (cnt == '0) begin
          state_nx = C_WAIT_WREC;
          cnt_nx   = LD_WREC;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      C_WAIT_WREC: begin
        if (cnt == '0) begin
          // Write recovery already includes precharge, so DONE is one cycle.
          state_nx = C_DONE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      C_AUTOREF: begin
        state_nx = C_WAIT_RFC;
        cnt_nx   = LD_RFC;
      end
      C_WAIT_RFC: begin
        if (cnt == '0) begin
          state_nx = C_REF_DONE;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      C_DONE: begin
        if (cnt == '0) begin
          state_nx = C_IDLE;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      C_REF_DONE: begin
        state_nx = C_IDLE;
      end
      default: begin
        state_nx = C_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; outputs are derived from the next state
  // so they line up with cmd_state in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= C_IDLE;
      cnt         <= '0;
      is_wr       <= 1'b0;
      ctrl_addr   <= '0;
      ref_tmr     <= '0;
      ref_pend    <= 1'b0;
      ref_overrun <= 1'b0;
      req_ready   <= 1'b0;
      rd_data_en  <= 1'b0;
      wr_data_en  <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      is_wr       <= is_wr_nx;
      ctrl_addr   <= addr_nx;
      ref_tmr     <= ref_tmr_nx;
      ref_pend    <= ref_pend_nx;
      ref_overrun <= ovr_nx;
      req_ready   <= (state_nx == C_IDLE) && init_done && !ref_pend_nx;
      rd_data_en  <= (state_nx == C_WAIT_RBST);
      wr_data_en  <= (state_nx == C_WAIT_WBST);
      done        <= (state_nx == C_DONE) && (state != C_DONE);
    end
  end

endmodule

// File: tb/tb_ddr_cmd_fsm.sv
// tb_ddr_cmd_fsm: directed bench for ddr_cmd_fsm with an expected-trace scoreboard.
// dut_a: defaults with a 64-cycle refresh interval; dut_b: 32-cycle interval, long write recovery.
// Inputs change on negedges; outputs are sampled on negedges.
module tb_ddr_cmd_fsm;

  logic        clk = 1'b0;
  logic        rst, init_done, req_valid, req_wr, b_valid;
  logic [24:0] req_addr;

  logic        a_ready, a_rd, a_wr, a_done, a_ovr;
  logic [3:0]  a_state;
  logic [24:0] a_addr;
  logic        b_ready, b_rd, b_wr, b_done, b_ovr;
  logic [3:0]  b_state;
  logic [24:0] b_addr;

  always #5 clk = ~clk;

  ddr_cmd_fsm #(.REF_INTERVAL(64)) dut_a (
    .clk(clk), .rst(rst), .init_done(init_done), .req_valid(req_valid), .req_wr(req_wr),
    .req_addr(req_addr), .req_ready(a_ready), .cmd_state(a_state), .ctrl_addr(a_addr),
    .rd_data_en(a_rd), .wr_data_en(a_wr), .done(a_done), .ref_overrun(a_ovr)
  );

  ddr_cmd_fsm #(.REF_INTERVAL(32), .T_WR_RP(60)) dut_b (
    .clk(clk), .rst(rst), .init_done(init_done), .req_valid(b_valid), .req_wr(req_wr),
    .req_addr(req_addr), .req_ready(b_ready), .cmd_state(b_state), .ctrl_addr(b_addr),
    .rd_data_en(b_rd), .wr_data_en(b_wr), .done(b_done), .ref_overrun(b_ovr)
  );

  typedef struct {
    logic [3:0] st;
    logic       rd;
    logic       wr;
    logic       dn;
    logic       rdy;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [24:0] cur_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Expected per-cycle view of n cycles in state st, from the interface definition.
  task automatic push(input logic [3:0] st, input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.st  = st;
      e.rd  = (st == 4'd5);
      e.wr  = (st == 4'd7);
      e.dn  = (st == 4'd11) && (i == 0);
      e.rdy = (st == 4'd0);
      exp_q.push_back(e);
    end
  endtask

  // Compare dut_a against the queued trace, one entry per cycle starting now.
  task automatic drain(input logic [24:0] addr_first, input logic [24:0] addr_rest,
                       input bit rel, input int drop_at);
    int i = 0;
    while (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("cmd_state", 32'(a_state), 32'(e.st));
      chk("rd_data_en", 32'(a_rd), 32'(e.rd));
      chk("wr_data_en", 32'(a_wr), 32'(e.wr));
      chk("done", 32'(a_done), 32'(e.dn));
      chk("req_ready", 32'(a_ready), 32'(e.rdy));
      chk("ctrl_addr", 32'(a_addr), 32'((i == 0) ? addr_first : addr_rest));
      if (i == drop_at) init_done = 1'b0;
      @(negedge clk);
      if (i == 0 && rel) begin
        req_valid = 1'b0;
        req_addr  = 25'($urandom);
        req_wr    = ~req_wr;
      end
      i++;
    end
  endtask

  // Issue one request at an IDLE cycle with req_ready high and follow it back to IDLE.
  task automatic do_txn(input bit wr, input logic [24:0] addr, input int drop_at);
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    push(4'd0, 1); push(4'd1, 1); push(4'd2, 2);
    if (wr) begin
      push(4'd6, 1); push(4'd7, 4); push(4'd8, 4); push(4'd11, 1);
    end else begin
      push(4'd3, 1); push(4'd4, 2); push(4'd5, 4); push(4'd11, 2);
    end
    drain(cur_addr, addr, 1'b1, drop_at);
    cur_addr = addr;
    chk("txn_end_state", 32'(a_state), 0);
    chk("txn_end_ready", 32'(a_ready), 32'(init_done));
  endtask

  task automatic wait_b(input logic [3:0] st, input int bound, input string tag);
    bit found = 1'b0;
    for (int i = 0; i < bound && !found; i++) begin
      @(negedge clk);
      if (b_state == st) found = 1'b1;
    end
    chk(tag, 32'(found), 1);
  endtask

  initial begin
    int bad;
    int k;
    bit found;

    // Reset with a request and init_done low.
    rst = 1'b0; init_done = 1'b0; req_valid = 1'b1; req_wr = 1'b0;
    req_addr = 25'h0012345; b_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(a_state), 0);
    chk("rst_addr", 32'(a_addr), 0);
    chk("rst_ready", 32'(a_ready), 0);
    chk("rst_rd_wr_done", 32'({a_rd, a_wr, a_done}), 0);
    chk("rst_ovr", 32'(a_ovr), 0);
    #2 rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (a_state !== 4'd0 || a_ready !== 1'b0) bad++;
    end
    chk("no_init_hold_violations", 32'(bad), 0);

    // Init completes; read, write, read, write back-to-back.
    req_valid = 1'b0; init_done = 1'b1;
    @(negedge clk);
    chk("ready_after_init", 32'(a_ready), 1);
    cur_addr = 25'h0;
    do_txn(1'b0, 25'h0012345, -1);
    do_txn(1'b1, 25'h1ABCDEF, -1);
    do_txn(1'b0, 25'h0AAAAAA, -1);
    do_txn(1'b1, 25'h1555555, -1);

    // Asynchronous reset in the middle of a write burst.
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 25'h0F0F0F0;
    repeat (6) @(negedge clk);
    chk("midop_wr_burst", 32'(a_wr), 1);
    req_valid = 1'b0; init_done = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("abort_state", 32'(a_state), 0);
    chk("abort_wr_en", 32'(a_wr), 0);
    chk("abort_addr", 32'(a_addr), 0);
    chk("abort_ready", 32'(a_ready), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Refresh: interval wrap sets pending at cycle 64, AUTOREFRESH on the cycle after.
    init_done = 1'b1;
    found = 1'b0; k = 0;
    for (int i = 1; i <= 200 && !found; i++) begin
      @(negedge clk);
      if (i == 63) chk("ready_before_wrap", 32'(a_ready), 1);
      if (i == 64) chk("ready_at_wrap", 32'(a_ready), 0);
      if (a_state != 4'd0) begin
        found = 1'b1;
        k = i;
      end
    end
    chk("autoref_cycle", 32'(k), 65);
    // A read arriving during refresh waits until REFRESH_DONE returns to IDLE.
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 25'h0777777;
    cur_addr = 25'h0;
    push(4'd9, 1); push(4'd10, 10); push(4'd12, 1);
    drain(25'h0, 25'h0, 1'b0, -1);
    do_txn(1'b0, 25'h0777777, -1);

    // init_done drops mid-write: the write completes, then IDLE accepts nothing.
    do_txn(1'b1, 25'h1234567, 6);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 25'h0246810;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (a_state !== 4'd0 || a_ready !== 1'b0) bad++;
    end
    chk("no_accept_without_init", 32'(bad), 0);
    chk("addr_held_while_idle", 32'(a_addr), 32'(cur_addr));
    init_done = 1'b1;
    @(negedge clk);
    chk("ready_after_reinit", 32'(a_ready), 1);
    do_txn(1'b0, 25'h0246810, -1);

    // Overrun on dut_b: one long write outlasts two refresh intervals.
    req_valid = 1'b0;
    #2 rst = 1'b0;
    init_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; init_done = 1'b1; b_valid = 1'b1; req_wr = 1'b1; req_addr = 25'h1000001;
    repeat (40) @(negedge clk);
    chk("b_ovr_single_wrap", 32'(b_ovr), 0);
    chk("b_busy_in_recovery", 32'(b_state), 8);
    wait_b(4'd9, 200, "b_reach_autoref");
    chk("b_ovr_set", 32'(b_ovr), 1);
    wait_b(4'd12, 50, "b_reach_ref_done");
    chk("b_ovr_after_ref", 32'(b_ovr), 1);
    wait_b(4'd1, 50, "b_next_write");
    chk("b_ovr_sticky", 32'(b_ovr), 1);
    b_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("b_ovr_cleared", 32'(b_ovr), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ddr_cmd_fsm.md
Name: ddr_cmd_fsm

Overview:
- Controller-side command sequencer for the DDR interface, sitting directly upstream of the command generator.
- Accepts read/write requests from the user port through a valid/ready handshake and runs the bank timing.
- Schedules periodic auto-refresh.
- Drives the 4-bit cmd_state and the latched 25-bit ctrl_addr that the command generator decodes into DDR pins.
- Also provides the read/write data-window enables for the datapath.

Parameters:
T_RCD, 2, ACTIVE-to-READ/WRITE delay in clk cycles (>=1)
CAS_LAT, 2, CAS latency in clk cycles (>=1)
BURST_LEN, 8, DDR burst length in beats; burst window = BURST_LEN/2 cycles
T_WR_RP, 4, write recovery plus auto-precharge time in cycles (>=1)
T_RP, 2, auto-precharge time after a read burst, in cycles (>=1)
T_RFC, 10, refresh cycle time in cycles (>=1)
REF_INTERVAL, 1560, cycles between refresh requests (>=T_RFC+16)

Ports:
clk  input  1  controller clock
rst  input  1  asynchronous active-low reset
init_done  input  1  initialisation sequencer is in its READY state
req_valid  input  1  user request valid
req_wr  input  1  1 = write, 0 = read; sampled with req_valid
req_addr  input  25  {bank[24:23], row[22:10], col[9:0]}
req_ready  output  1  request accepted when req_valid && req_ready
cmd_state  output  4  current command state, shared c_* encoding
ctrl_addr  output  25  latched request address
rd_data_en  output  1  read data window to the datapath
wr_data_en  output  1  write data window to the datapath
done  output  1  one-cycle pulse at completion of a read or write
ref_overrun  output  1  sticky; a refresh interval expired while a refresh was still pending

Behaviour:
- cmd_state encoding (shared parameters include):
  - IDLE=0, ACTIVE=1, WAIT_tRCD=2, READ=3, WAIT_CAS_LATENCY=4
  - WAIT_END_OF_R_BURST=5, WRITE=6, WAIT_END_OF_W_BURST=7, WAIT_WRITE_RECOVERY=8
  - AUTOREFRESH=9, WAIT_tRFC=10, DONE=11, REFRESH_DONE=12
- Codes 13-15 are unreachable; if one is entered, the next state is IDLE.
- Reset (async, rst low) values:
  - cmd_state = IDLE, ctrl_addr = 0
  - req_ready, rd_data_en, wr_data_en, done, ref_overrun = 0
  - refresh timer = 0, refresh_pending = 0, wait counter = 0
- Reset mid-operation aborts immediately to IDLE; no state is preserved.
- All outputs are registered on posedge clk.
- req_ready = (cmd_state==IDLE) && init_done && !refresh_pending. It is registered and recomputed from the next state.
- IDLE priority:
  - refresh_pending -> AUTOREFRESH
  - else, on handshake: latch ctrl_addr <= req_addr and latch req_wr, then go to ACTIVE
  - otherwise stay in IDLE
- Every state without a listed wait count lasts exactly 1 cycle.
- A wait state lasting N cycles loads its down-counter with N-1 on entry and exits when the counter reads 0.
- Read path:
  - ACTIVE -> WAIT_tRCD (T_RCD) -> READ -> WAIT_CAS_LATENCY (CAS_LAT)
  - -> WAIT_END_OF_R_BURST (BURST_LEN/2) -> DONE (T_RP) -> IDLE
- Write path:
  - ACTIVE -> WAIT_tRCD (T_RCD) -> WRITE -> WAIT_END_OF_W_BURST (BURST_LEN/2)
  - -> WAIT_WRITE_RECOVERY (T_WR_RP) -> DONE (1 cycle) -> IDLE
- Refresh path: AUTOREFRESH -> WAIT_tRFC (T_RFC) -> REFRESH_DONE -> IDLE.
- READ and WRITE always use auto-precharge; this block never issues an explicit precharge.
- rd_data_en is high exactly while cmd_state==WAIT_END_OF_R_BURST.
- wr_data_en is high exactly while cmd_state==WAIT_END_OF_W_BURST.
- done is high only in the first cycle of DONE.
- ctrl_addr is stable from ACTIVE through DONE. It changes only on an accepted handshake.
- Refresh timer:
  - Counts 0..REF_INTERVAL-1 while init_done=1.
  - Held at 0 while init_done=0.
  - On wrap it sets refresh_pending.
  - refresh_pending clears on entry to AUTOREFRESH.
  - If the timer wraps while refresh_pending is already 1: set ref_overrun (sticky until reset); pending stays 1.
- Simultaneous request and refresh wrap in IDLE: the request wins if req_ready was already 1 that cycle; the refresh follows the request's DONE.
- Requests arriving while busy are not accepted (req_ready=0). The user must hold req_valid and req_addr.
- If init_done falls mid-transaction, the transaction completes. IDLE then accepts nothing until init_done=1.

Test Plan:
- Reset with req_valid=1, init_done=0 -> req_ready=0, cmd_state=0, no transition for 100 cycles; rst release mid-count is clean.
- Single read to addr 0x1_2345 with defaults:
  - cmd_state sequence 0,1,2,2,3,4,4,5x4,11,11,0
  - rd_data_en high for 4 cycles; done pulses once
  - ctrl_addr=0x0012345 throughout
- Single write with defaults:
  - cmd_state sequence 0,1,2,2,6,7x4,8x4,11,0
  - wr_data_en high for 4 cycles; req_ready low from handshake until back in IDLE
- Refresh with REF_INTERVAL=64:
  - after 64 init_done cycles, AUTOREFRESH occurs; WAIT_tRFC lasts 10 cycles, then REFRESH_DONE, then IDLE
  - a read request pending during this is accepted only after the refresh
- Overrun with REF_INTERVAL=32 and a long back-to-back write stream:
  - a second wrap while pending sets ref_overrun=1
  - the flag stays set after the refresh executes; it clears only on rst
- Back-to-back requests, reads and writes alternating: each is accepted exactly one cycle after the prior return to IDLE; ctrl_addr updates only at a handshake.
